// File: rtl/lc3_pkg.sv
`timescale 1ns/1ps
// Shared LC-3 definitions: control-word encodings, the reset PC and the machine word type.
// The control unit imports this same package so both sides agree on the encodings.
package lc3_pkg;

  typedef logic [15:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 16'h3000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_NOT   = 2'b10,
    ALU_PASSA = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_EAB  = 2'b01,
    PC_BUS  = 2'b10,
    PC_HOLD = 2'b11
  } sel_pc_e;

  typedef enum logic [1:0] {
    EAB2_ZERO  = 2'b00,
    EAB2_OFF6  = 2'b01,
    EAB2_OFF9  = 2'b10,
    EAB2_OFF11 = 2'b11
  } sel_eab2_e;

  // Sign-extend the low w bits of v to a full word.
  function automatic word_t sext(input word_t v, input int unsigned w);
    logic signed [15:0] t;
    t = signed'(v << (16 - w));
    return word_t'(t >>> (16 - w));
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
`timescale 1ns/1ps
// LC-3 general purpose register file: 8 x 16, two combinational read ports, one write port.
// A same-cycle read of the register being written returns the old contents.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [2:0]  wa_i,
  input  logic [15:0] wd_i,
  input  logic [2:0]  ra1_i,
  input  logic [2:0]  ra2_i,
  output logic [15:0] rd1_o,
  output logic [15:0] rd2_o
);

  word_t regs_q [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = regs_q[ra1_i];
  assign rd2_o = regs_q[ra2_i];

endmodule

// File: rtl/lc3_datapath.sv
`timescale 1ns/1ps
// LC-3 datapath: architectural state, shared bus, ALU, address adder and PC/MAR/MDR muxes,
// driven each cycle by the control word from the LC-3 control unit.
module lc3_datapath
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  aluControl,
  input  logic        enaALU,
  input  logic        enaMARM,
  input  logic        enaMDR,
  input  logic        enaPC,
  input  logic        selMAR,
  input  logic        selEAB1,
  input  logic [1:0]  selEAB2,
  input  logic [1:0]  selPC,
  input  logic        selMDR,
  input  logic        ldPC,
  input  logic        ldIR,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic [2:0]  SR1,
  input  logic [2:0]  SR2,
  input  logic [2:0]  DR,
  input  logic        regWE,
  input  logic [15:0] memRData,
  output logic [15:0] IR,
  output logic        N,
  output logic        Z,
  output logic        P,
  output logic [15:0] memAddr,
  output logic [15:0] memWData,
  output logic [15:0] bus,
  output logic        busConflict
);

  word_t pc_q, ir_q, mar_q, mdr_q;
  logic  n_q, z_q, p_q;
  word_t sr1_data, sr2_data, alu_b, alu_out;
  word_t eab1, eab2, eab, marmux, pc_d, mdr_d;

  lc3_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we_i  (regWE),
    .wa_i  (DR),
    .wd_i  (bus),
    .ra1_i (SR1),
    .ra2_i (SR2),
    .rd1_o (sr1_data),
    .rd2_o (sr2_data)
  );

  always_comb begin
    alu_b = ir_q[5] ? sext(ir_q, 5) : sr2_data;
    unique case (alu_op_e'(aluControl))
      ALU_ADD: alu_out = sr1_data + alu_b;
      ALU_AND: alu_out = sr1_data & alu_b;
      ALU_NOT: alu_out = ~sr1_data;
      default: alu_out = sr1_data;
    endcase
  end

  always_comb begin
    eab1 = selEAB1 ? sr1_data : pc_q;
    unique case (sel_eab2_e'(selEAB2))
      EAB2_ZERO: eab2 = '0;
      EAB2_OFF6: eab2 = sext(ir_q, 6);
      EAB2_OFF9: eab2 = sext(ir_q, 9);
      default:   eab2 = sext(ir_q, 11);
    endcase
    eab    = eab1 + eab2;
    marmux = selMAR ? eab : {8'h00, ir_q[7:0]};
  end

  // Priority only matters when the control unit misbehaves; busConflict flags that case.
  always_comb begin
    if (enaPC)        bus = pc_q;
    else if (enaMDR)  bus = mdr_q;
    else if (enaALU)  bus = alu_out;
    else if (enaMARM) bus = marmux;
    else              bus = '0;
  end

  assign busConflict = (enaPC  & (enaMDR | enaALU | enaMARM)) |
                       (enaMDR & (enaALU | enaMARM)) |
                       (enaALU & enaMARM);

  always_comb begin
    unique case (sel_pc_e'(selPC))
      PC_INC:  pc_d = pc_q + 16'd1;
      PC_EAB:  pc_d = eab;
      PC_BUS:  pc_d = bus;
      default: pc_d = pc_q;
    endcase
    mdr_d = selMDR ? memRData : bus;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b1;
      p_q   <= 1'b0;
    end else begin
      if (ldPC)  pc_q  <= pc_d;
      if (ldIR)  ir_q  <= bus;
      if (ldMAR) mar_q <= bus;
      if (ldMDR) mdr_q <= mdr_d;
      if (regWE) begin
        n_q <= bus[15];
        z_q <= (bus == '0);
        p_q <= ~bus[15] & (bus != '0);
      end
    end
  end

  assign IR       = ir_q;
  assign N        = n_q;
  assign Z        = z_q;
  assign P        = p_q;
  assign memAddr  = mar_q;
  assign memWData = mdr_q;

endmodule

// File: tb/tb_lc3_datapath.sv
`timescale 1ns/1ps
// Scoreboard bench for lc3_datapath: expectations are queued as stimulus is applied and
// popped when the corresponding DUT value is observed.
module tb_lc3_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  aluControl;
  logic        enaALU, enaMARM, enaMDR, enaPC;
  logic        selMAR, selEAB1, selMDR;
  logic [1:0]  selEAB2, selPC;
  logic        ldPC, ldIR, ldMAR, ldMDR, regWE;
  logic [2:0]  SR1, SR2, DR;
  logic [15:0] memRData = 16'h0000;
  logic [15:0] IR, memAddr, memWData, bus;
  logic        N, Z, P, busConflict;

  lc3_datapath dut (
    .clk(clk), .reset(reset), .aluControl(aluControl),
    .enaALU(enaALU), .enaMARM(enaMARM), .enaMDR(enaMDR), .enaPC(enaPC),
    .selMAR(selMAR), .selEAB1(selEAB1), .selEAB2(selEAB2), .selPC(selPC), .selMDR(selMDR),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .SR1(SR1), .SR2(SR2), .DR(DR), .regWE(regWE), .memRData(memRData),
    .IR(IR), .N(N), .Z(Z), .P(P), .memAddr(memAddr), .memWData(memWData),
    .bus(bus), .busConflict(busConflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [15:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 16'(sb_q.size()), 16'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic idle();
    aluControl = 2'b00;
    enaALU = 1'b0; enaMARM = 1'b0; enaMDR = 1'b0; enaPC = 1'b0;
    selMAR = 1'b0; selEAB1 = 1'b0; selEAB2 = 2'b00; selPC = 2'b11; selMDR = 1'b0;
    ldPC = 1'b0; ldIR = 1'b0; ldMAR = 1'b0; ldMDR = 1'b0; regWE = 1'b0;
    SR1 = 3'd0; SR2 = 3'd0; DR = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [15:0] v);
    memRData = v; selMDR = 1'b1; ldMDR = 1'b1;
    step();
  endtask

  task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
    load_mdr(v);
    enaMDR = 1'b1; regWE = 1'b1; DR = r;
    step();
  endtask

  task automatic set_ir(input logic [15:0] v);
    load_mdr(v);
    enaMDR = 1'b1; ldIR = 1'b1;
    step();
  endtask

  task automatic set_pc(input logic [15:0] v);
    load_mdr(v);
    enaMDR = 1'b1; ldPC = 1'b1; selPC = 2'b10;
    step();
  endtask

  task automatic read_pc(output logic [15:0] v);
    enaPC = 1'b1;
    #1 v = bus;
    enaPC = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
    SR1 = r; aluControl = 2'b11; enaALU = 1'b1;
    #1 v = bus;
    enaALU = 1'b0;
  endtask

  function automatic logic [15:0] nzp();
    return {13'd0, N, Z, P};
  endfunction

  initial begin
    logic [15:0] v;
    logic [15:0] r1_old;
    idle();
    #12 reset = 1'b0;
    step();

    // Power-up reset state
    sb_push("rst0_pc", 16'h3000);  read_pc(v); sb_pop(v);
    sb_push("rst0_nzp", 16'h0002); sb_pop(nzp());
    sb_push("rst0_ir", 16'h0000);  sb_pop(IR);

    // Asynchronous reset in the middle of a cycle
    set_pc(16'h3005);
    set_reg(3'd1, 16'h1234);
    sb_push("pre_rst_pc", 16'h3005); read_pc(v); sb_pop(v);
    #1 reset = 1'b1;
    #1;
    sb_push("rst_pc", 16'h3000);   read_pc(v); sb_pop(v);
    sb_push("rst_r1", 16'h0000);   read_reg(3'd1, v); sb_pop(v);
    sb_push("rst_nzp", 16'h0002);  sb_pop(nzp());
    sb_push("rst_mdr", 16'h0000);  sb_pop(memWData);
    sb_push("rst_ir", 16'h0000);   sb_pop(IR);
    reset = 1'b0;
    step();

    // Fetch: MAR<=PC, PC<=PC+1; MDR<=mem; IR<=MDR
    enaPC = 1'b1; ldMAR = 1'b1; ldPC = 1'b1; selPC = 2'b00;
    step();
    sb_push("fetch_mar", 16'h3000); sb_pop(memAddr);
    sb_push("fetch_pc", 16'h3001);  read_pc(v); sb_pop(v);
    memRData = 16'h1261; selMDR = 1'b1; ldMDR = 1'b1;
    step();
    enaMDR = 1'b1; ldIR = 1'b1;
    step();
    sb_push("fetch_ir", 16'h1261); sb_pop(IR);

    // ADD immediate, including read-during-write of R1
    set_reg(3'd1, 16'h0005);
    r1_old = 16'h0005;
    SR1 = 3'd1; DR = 3'd1; aluControl = 2'b00; enaALU = 1'b1; regWE = 1'b1;
    #1;
    sb_push("add_bus_rdw", r1_old + 16'd1); sb_pop(bus);
    step();
    sb_push("add_r1", 16'h0006);   read_reg(3'd1, v); sb_pop(v);
    sb_push("add_nzp", 16'h0001);  sb_pop(nzp());
    set_reg(3'd1, 16'hFFFF);
    SR1 = 3'd1; DR = 3'd1; aluControl = 2'b00; enaALU = 1'b1; regWE = 1'b1;
    step();
    sb_push("add_wrap_r1", 16'h0000); read_reg(3'd1, v); sb_pop(v);
    sb_push("add_wrap_nzp", 16'h0002); sb_pop(nzp());

    // NOT and register-register AND
    set_reg(3'd2, 16'h00F0);
    SR1 = 3'd2; DR = 3'd4; aluControl = 2'b10; enaALU = 1'b1; regWE = 1'b1;
    step();
    sb_push("not_r4", ~16'h00F0);  read_reg(3'd4, v); sb_pop(v);
    sb_push("not_nzp", 16'h0004);  sb_pop(nzp());
    set_reg(3'd3, 16'h0F0F);
    set_ir(16'h5083);
    SR1 = 3'd2; SR2 = 3'd3; DR = 3'd5; aluControl = 2'b01; enaALU = 1'b1; regWE = 1'b1;
    step();
    sb_push("and_r5", 16'h00F0 & 16'h0F0F); read_reg(3'd5, v); sb_pop(v);
    sb_push("and_nzp", 16'h0002);  sb_pop(nzp());

    // Branch target via EAB with a negative 9-bit offset, plus MARMux paths
    set_pc(16'h3010);
    set_ir(16'h01FE);
    enaMARM = 1'b1; selMAR = 1'b1; selEAB1 = 1'b0; selEAB2 = 2'b10;
    #1;
    sb_push("marm_eab", 16'h3010 + 16'hFFFE); sb_pop(bus);
    selMAR = 1'b0;
    #1;
    sb_push("marm_zext", 16'h00FE); sb_pop(bus);
    enaMARM = 1'b0; selEAB1 = 1'b0; selEAB2 = 2'b10; selPC = 2'b01; ldPC = 1'b1;
    step();
    sb_push("br_pc", 16'h300E); read_pc(v); sb_pop(v);

    // Bus conflict and empty bus
    SR1 = 3'd4; aluControl = 2'b11; enaALU = 1'b1; enaPC = 1'b1;
    #1;
    sb_push("conf_flag", 16'h0001); sb_pop({15'd0, busConflict});
    sb_push("conf_bus", 16'h300E);  sb_pop(bus);
    idle();
    #1;
    sb_push("empty_bus", 16'h0000);  sb_pop(bus);
    sb_push("empty_flag", 16'h0000); sb_pop({15'd0, busConflict});

    // All loads capture the same bus value; PC advances in the same edge
    enaPC = 1'b1; ldIR = 1'b1; ldMAR = 1'b1; ldMDR = 1'b1; selMDR = 1'b0;
    regWE = 1'b1; DR = 3'd6; ldPC = 1'b1; selPC = 2'b00;
    step();
    sb_push("all_ir", 16'h300E);  sb_pop(IR);
    sb_push("all_mar", 16'h300E); sb_pop(memAddr);
    sb_push("all_mdr", 16'h300E); sb_pop(memWData);
    sb_push("all_r6", 16'h300E);  read_reg(3'd6, v); sb_pop(v);
    sb_push("all_pc", 16'h300F);  read_pc(v); sb_pop(v);

    // PC+1 wrap and hold with ldPC asserted
    set_pc(16'hFFFF);
    ldPC = 1'b1; selPC = 2'b00;
    step();
    sb_push("pc_wrap", 16'h0000); read_pc(v); sb_pop(v);
    set_pc(16'h4321);
    ldPC = 1'b1; selPC = 2'b11;
    step();
    sb_push("pc_hold", 16'h4321); read_pc(v); sb_pop(v);

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lc3_datapath.md
# lc3_datapath

The LC-3 datapath executes the control word issued each cycle by the LC-3 control unit. It holds the architectural state (PC, IR, MAR, MDR, NZP, eight GPRs), implements the single shared bus, the ALU, the address adder and the PC/MAR/MDR muxes. It returns IR and N/Z/P to the control unit, and presents MAR/MDR to external memory.

## Interface
- RESET_PC, 16'h3000, PC value loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- aluControl  in  2  00 ADD, 01 AND, 10 NOT, 11 PASSA.
- enaALU, enaMARM, enaMDR, enaPC  in  1 each  bus drive enables.
- selMAR  in  1  0: zext(IR[7:0]), 1: EAB adder output.
- selEAB1  in  1  0: PC, 1: SR1 read data.
- selEAB2  in  2  00: 0, 01: sext(IR[5:0]), 10: sext(IR[8:0]), 11: sext(IR[10:0]).
- selPC  in  2  00: PC+1, 01: EAB, 10: bus, 11: hold.
- selMDR  in  1  0: bus, 1: memRData.
- ldPC, ldIR, ldMAR, ldMDR  in  1 each  register load strobes.
- SR1, SR2, DR  in  3 each  register file addresses.
- regWE  in  1  write bus into GPR[DR] and update NZP.
- memRData  in  16  read data from external memory (combinational read of memAddr).
- IR  out  16  instruction register.
- N, Z, P  out  1 each  condition codes.
- memAddr  out  16  = MAR.
- memWData  out  16  = MDR.
- bus  out  16  current bus value (debug/trace).
- busConflict  out  1  more than one bus enable asserted.

## Operation
- Bus: one-hot mux of ALU, MARMux, MDR, PC. No enable -> 16'h0000. Multiple enables -> busConflict=1, bus resolved by priority PC > MDR > ALU > MARMux.
- ALU: A = GPR[SR1]. B = IR[5] ? sext(IR[4:0]) : GPR[SR2]. ADD is 16-bit modulo, carry discarded. NOT/PASSA ignore B.
- EAB = EAB1 + EAB2, 16-bit modulo. MARMux = selMAR ? EAB : {8'h00, IR[7:0]}.
- Register file: two combinational read ports (SR1, SR2), one write port (DR, regWE). GPR[DR] <= bus on edge.
- NZP on regWE edge: N = bus[15], Z = (bus == 0), P = !bus[15] && bus != 0. Exactly one of N/Z/P is always high.
- ldPC: PC <= selPC mux. With selPC=11, PC holds even when ldPC=1.
- ldIR: IR <= bus. ldMAR: MAR <= bus. ldMDR: MDR <= selMDR ? memRData : bus.
- Memory write strobe goes from the control unit directly to memory. The datapath only supplies memAddr and memWData.

## Timing
- Reset (async, any time, including mid-instruction): PC=RESET_PC, IR=0, MAR=0, MDR=0, GPR0..7=0, N=0 Z=1 P=0. Outputs take these values without waiting for a clock edge. The first load happens on the first rising edge after reset deasserts.
- All reads and the bus are combinational from current state and control inputs. All loads take effect at the next rising edge, so latency is 1 cycle.
- Read-during-write: same-cycle read of GPR[DR] returns the old value; the new value is visible next cycle.
- enaPC with ldPC, selPC=00: the bus shows the old PC and PC becomes old+1 at the edge (fetch idiom).
- PC+1 and EAB wrap 16'hFFFF -> 16'h0000 without error.
- Simultaneous ldIR/ldMAR/ldMDR/ldPC/regWE all capture the same bus value in the same edge.

## Structure
- Shared package lc3_pkg: ALU op codes, selPC codes, selEAB2 codes, RESET_PC default, a 16-bit word typedef. The control unit imports the same package.
- One sub-module: lc3_regfile (8x16, 2R1W, async reset to zero). The rest stays flat in lc3_datapath.

## Test plan
- Reset: assert reset mid-cycle with PC=16'h3005 -> PC=16'h3000, Z=1, all GPRs 0 before the next edge.
- Fetch: memRData=16'h1261 at MAR=16'h3000, run the MAR<=PC/PC+1, MDR<=mem, IR<=MDR sequence -> IR=16'h1261, PC=16'h3001.
- ADD imm: GPR1=16'h0005, IR=16'h1261 (R1<=R1+1), enaALU, regWE, DR=1 -> GPR1=16'h0006, P=1. Repeat with GPR1=16'hFFFF -> result 16'h0000, Z=1.
- NOT/AND: GPR2=16'h00F0, NOT -> 16'hFF0F, N=1. AND with GPR3=16'h0F0F -> 16'h0000, Z=1.
- Branch/JSR address: PC=16'h3010, IR[8:0]=9'h1FE, selEAB1=0, selEAB2=10, selPC=01, ldPC -> PC=16'h300E. With PC=16'hFFFF, selPC=00 -> 16'h0000.
- Bus conflict: enaPC=enaALU=1 -> busConflict=1, bus equals PC. No enables -> bus=16'h0000, busConflict=0.
